wptr_full_prog: RTL and testbench

//  Write-domain pointer and flag generator for the async FIFO, next generation of the basic

---
 rtl/afifo_pkg.sv | 30 +++
 rtl/afifo_gray2bin.sv | 26 ++
 rtl/wptr_full_prog.sv | 100 ++++++++++
 tb/tb_wptr_full_prog.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// ---------------------------------------------------------------------------
// afifo_pkg
// Shared definitions for the asynchronous FIFO pointer blocks: default depth
// and Gray/binary conversion helpers. The helpers work on 32-bit words; the
// caller zero-extends narrower pointers and truncates the result. Zero upper
// bits do not disturb either conversion.
// ---------------------------------------------------------------------------
package afifo_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;
    localparam int DEPTH            = 2 ** ADDRSIZE_DEFAULT;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB downwards.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_gray2bin.sv
// ---------------------------------------------------------------------------
// afifo_gray2bin
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write-side and read-side pointer blocks.
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  equivalent binary value
// ---------------------------------------------------------------------------
module afifo_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        logic acc;
        bin = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/wptr_full_prog.sv
// ---------------------------------------------------------------------------
// wptr_full_prog
// Write-domain pointer and flag generator for the asynchronous FIFO. Keeps
// binary and Gray write pointers, a registered full flag, a conservative
// fill level, a programmable almost-full flag and a sticky overflow flag.
// Ports:
//   wclk          in   1           write clock, rising edge
//   wrst          in   1           synchronous active-high reset
//   winc          in   1           write request, accepted when wfull==0
//   wq2_rptr      in   ADDRSIZE+1  Gray read pointer synchronised to wclk
//   afull_thresh  in   ADDRSIZE+1  almost-full threshold in words
//   clr_ovf       in   1           clears woverflow (a same-cycle set wins)
//   waddr         out  ADDRSIZE    RAM write address
//   wptr          out  ADDRSIZE+1  registered Gray write pointer
//   wfull         out  1           registered full flag
//   walmost_full  out  1           registered, wlevel >= afull_thresh
//   wlevel        out  ADDRSIZE+1  registered occupancy estimate
//   woverflow     out  1           sticky write-while-full flag
// ---------------------------------------------------------------------------
module wptr_full_prog
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                clr_ovf,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int PTR_W = ADDRSIZE + 1;

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              woverflow_q, woverflow_d;

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] full_match;
    logic              wr_ok;

    afifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // The write pointer is exactly one lap ahead of the read pointer when the
    // two top Gray bits are inverted and the rest match.
    assign full_match = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        wr_ok          = winc & ~wfull_q;
        wbin_d         = wbin_q + PTR_W'(wr_ok);
        wptr_d         = PTR_W'(bin2gray(32'(wbin_d)));
        wfull_d        = (wptr_d == full_match);
        // Modular difference; the synchronised read pointer lags, so this
        // never under-reports the true occupancy.
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= afull_thresh);
        woverflow_d    = (winc & wfull_q) | (woverflow_q & ~clr_ovf);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_prog.sv
module tb_wptr_full_prog;

    localparam int A     = 4;
    localparam int DEPTH = 16;
    localparam int MOD   = 32;

    logic         wclk = 1'b0;
    logic         wrst;
    logic         winc;
    logic [A:0]   wq2_rptr;
    logic [A:0]   afull_thresh;
    logic         clr_ovf;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wfull;
    logic         walmost_full;
    logic [A:0]   wlevel;
    logic         woverflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: number of words accepted (mod 32), flags, and the
    // binary read position the bench presents as a Gray pointer.
    int m_wbin, m_level, rb, thresh;
    bit m_full, m_af, m_ovf;

    wptr_full_prog #(.ADDRSIZE(A)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .afull_thresh (afull_thresh),
        .clr_ovf      (clr_ovf),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    // One clock: drive inputs, predict from occupancy arithmetic, compare.
    task automatic tick(input bit w, input bit clr, input bit rst);
        int acc, nb, lvl;
        winc         = w;
        clr_ovf      = clr;
        wrst         = rst;
        wq2_rptr     = 5'(to_gray(rb));
        afull_thresh = 5'(thresh);
        if (rst) begin
            m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            acc     = (w && !m_full) ? 1 : 0;
            nb      = (m_wbin + acc) % MOD;
            lvl     = (nb - rb + MOD) % MOD;
            m_ovf   = (w && m_full) || (m_ovf && !clr);
            m_wbin  = nb;
            m_level = lvl;
            m_full  = (lvl == DEPTH);
            m_af    = (lvl >= thresh);
        end
        @(posedge wclk);
        #1;
        chk("wptr",   int'(wptr),         to_gray(m_wbin));
        chk("waddr",  int'(waddr),        m_wbin % DEPTH);
        chk("wfull",  int'(wfull),        int'(m_full));
        chk("wlevel", int'(wlevel),       m_level);
        chk("afull",  int'(walmost_full), int'(m_af));
        chk("ovf",    int'(woverflow),    int'(m_ovf));
    endtask

    initial begin
        rb = 0; thresh = 16;
        winc = 0; clr_ovf = 0; wrst = 1;
        wq2_rptr = '0; afull_thresh = 5'(thresh);

        // Reset state
        tick(1, 0, 1);
        tick(0, 0, 1);
        chk("rst_wptr", int'(wptr), 0);

        // Fill 16 words
        for (int i = 0; i < 16; i++) tick(1, 0, 0);
        chk("fill_full",  int'(wfull),  1);
        chk("fill_level", int'(wlevel), 16);
        chk("fill_waddr", int'(waddr),  0);
        chk("fill_wptr",  int'(wptr),   5'b11000);

        // Overflow, set wins over clear, then clear alone
        tick(1, 0, 0);
        chk("ovf_set",   int'(woverflow), 1);
        chk("ovf_wptr",  int'(wptr),      5'b11000);
        chk("ovf_level", int'(wlevel),    16);
        tick(1, 1, 0);
        chk("ovf_setwins", int'(woverflow), 1);
        tick(0, 1, 0);
        chk("ovf_clr", int'(woverflow), 0);

        // Drain to empty, then 20 writes with the read pointer tracking
        rb = 16;
        tick(0, 0, 0);
        chk("drain_full",  int'(wfull),  0);
        chk("drain_level", int'(wlevel), 0);
        for (int i = 0; i < 20; i++) begin
            rb = m_wbin;
            tick(1, 0, 0);
        end
        chk("wrap_waddr", int'(waddr), 4);

        // Almost-full at 12
        rb = 0; thresh = 12;
        tick(0, 0, 1);
        for (int i = 0; i < 11; i++) tick(1, 0, 0);
        chk("af_11", int'(walmost_full), 0);
        tick(1, 0, 0);
        chk("af_12",  int'(walmost_full), 1);
        chk("lvl_12", int'(wlevel),       12);

        // Threshold 0 reads 1 from the first edge after reset
        thresh = 0;
        tick(0, 0, 1);
        chk("af0_rst", int'(walmost_full), 0);
        tick(0, 0, 0);
        chk("af0_on", int'(walmost_full), 1);

        // Reset mid-operation together with a write
        thresh = 16;
        for (int i = 0; i < 5; i++) tick(1, 0, 0);
        tick(1, 0, 1);
        chk("midrst_level", int'(wlevel), 0);
        chk("midrst_wptr",  int'(wptr),   0);

        // Simultaneous write and read advance at level 8
        for (int i = 0; i < 8; i++) tick(1, 0, 0);
        chk("sim_pre", int'(wlevel), 8);
        rb = 1;
        tick(1, 0, 0);
        chk("sim_level", int'(wlevel), 8);
        chk("sim_wptr",  int'(wptr),   to_gray(9));

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int occ;
            occ = (m_wbin - rb + MOD) % MOD;
            if (occ > 0 && $urandom_range(0, 99) < 45) rb = (rb + 1) % MOD;
            if ($urandom_range(0, 99) < 3) thresh = $urandom_range(0, DEPTH);
            if ($urandom_range(0, 499) == 0) begin
                rb = 0;
                tick(1'($urandom_range(0, 1)), 0, 1);
            end else begin
                tick(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
